// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared widths, parameter defaults and response record
package imem_responder_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;
    localparam int DEF_QDEPTH      = 4;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              err;
    } rsp_t;

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// rtl/imem_responder_rsp_fifo.sv - synchronous FIFO of completed response records
module rsp_fifo
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  rsp_t i_wdata,
    input  logic i_pop,
    output logic o_empty,
    output rsp_t o_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_t          r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= f_next(r_wptr);
            if (i_pop)  r_rptr <= f_next(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory with fixed-latency, in-order, backpressured responses
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int QDEPTH      = DEF_QDEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [WORD_W-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WORD_W-1:0]              rsp_data,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [WORD_W-1:0]              load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int NS = LATENCY - 1;

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic              r_run;
    logic [CW-1:0]     r_count;

    logic              w_accept;
    logic              w_xfer;
    logic [AW-1:0]     w_idx;
    logic              w_err;
    logic [WORD_W-1:0] w_word;
    rsp_t              w_new;
    logic              w_push;
    rsp_t              w_push_data;
    logic              w_empty;
    rsp_t              w_head;

    assign w_accept = req_valid && req_ready;
    assign w_xfer   = rsp_valid && rsp_ready;
    assign w_idx    = req_addr[AW+1:2];
    assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr[WORD_W-1:AW+2] != '0);
    // Write-first bypass so a same-cycle load is visible to the fetch.
    assign w_word   = (load_en && (load_addr == w_idx)) ? load_data : r_mem[w_idx];
    assign w_new    = '{data: (w_err ? '0 : w_word), err: w_err};

    always_ff @(posedge clk) begin
        if (load_en) r_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_count <= '0;
        end else begin
            r_run <= 1'b1;
            case ({w_accept, w_xfer})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_ready = r_run && (r_count < CW'(QDEPTH));

    // LATENCY-1 delay stages, then the FIFO write adds the final cycle.
    generate
        if (NS == 0) begin : g_direct
            assign w_push      = w_accept;
            assign w_push_data = w_new;
        end else begin : g_pipe
            logic [NS-1:0] r_pv;
            rsp_t          r_pd [NS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_accept;
                    for (int i = 1; i < NS; i++) r_pv[i] <= r_pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pd[0] <= w_new;
                for (int i = 1; i < NS; i++) r_pd[i] <= r_pd[i-1];
            end

            assign w_push      = r_pv[NS-1];
            assign w_push_data = r_pd[NS-1];
        end
    endgenerate

    // Outstanding bound guarantees the FIFO never overflows, so no stall path.
    rsp_fifo #(.DEPTH(QDEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_xfer),
        .o_empty (w_empty),
        .o_rdata (w_head)
    );

    assign rsp_valid = !w_empty;
    assign rsp_data  = rsp_valid ? w_head.data : '0;
    assign rsp_err   = rsp_valid && w_head.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
module tb_imem_responder;
    import imem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    int checks   = 0;
    int failures = 0;
    int n_xfer   = 0;
    int base;

    rsp_t        q[$];
    logic [31:0] mdl [256];
    logic        hold_prev = 1'b0;
    rsp_t        hold_val;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .QDEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 40) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < 40), 1);
    endtask

    always @(negedge clk) begin
        rsp_t        e;
        rsp_t        got;
        logic [7:0]  idx;
        if (!rst_n) begin
            chk("reset_rsp_valid", rsp_valid, 0);
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, hold_val.data);
                chk("hold_err", rsp_err, hold_val.err);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                end
                n_xfer++;
            end
            hold_prev = rsp_valid && !rsp_ready;
            got.data  = rsp_data;
            got.err   = rsp_err;
            hold_val  = got;
            if (req_valid && req_ready) begin
                idx   = req_addr[9:2];
                e.err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h400);
                if (e.err)                              e.data = 32'h0;
                else if (load_en && load_addr == idx)   e.data = load_data;
                else                                    e.data = mdl[idx];
                q.push_back(e);
            end
        end
        if (load_en) mdl[load_addr] = load_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tbl [5];
        tbl = '{32'h400, 32'h2, 32'hFFFF_FFFC, 32'h3FC, 32'h1C};
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid_0", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);

        for (int i = 0; i < 8; i++) begin
            step();
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = (i == 0) ? 32'h2008_0005 : (i == 1) ? 32'h8C09_0004
                                 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        step(); load_addr = 8'd255; load_data = 32'hCAFE_F00D;
        step(); load_en = 1'b0;

        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", req_ready, 0);
        step();
        chk("ready_after_release", req_ready, 1);

        req_valid = 1'b1; req_addr = 32'h0;
        step(); req_addr = 32'h4;
        @(negedge clk);
        chk("lat_early_valid", rsp_valid, 0);
        step(); req_valid = 1'b0;
        @(negedge clk);
        chk("lat2_valid", rsp_valid, 1);
        chk("lat2_data", rsp_data, 32'h2008_0005);
        chk("lat2_err", rsp_err, 0);
        step();
        @(negedge clk);
        chk("lat3_valid", rsp_valid, 1);
        chk("lat3_data", rsp_data, 32'h8C09_0004);
        drain();

        req_valid = 1'b1; req_addr = 32'h1;
        step(); req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("misalign_valid", rsp_valid, 1);
        chk("misalign_err", rsp_err, 1);
        chk("misalign_data", rsp_data, 0);
        drain();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = tbl[i];
            step();
        end
        req_valid = 1'b0;
        drain();

        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            @(negedge clk);
            chk("fill_ready", req_ready, 32'(i < 4));
            step();
        end
        req_valid = 1'b0;
        step(); step();
        @(negedge clk);
        chk("full_ready", req_ready, 0);
        chk("full_head_valid", rsp_valid, 1);
        chk("full_head_data", rsp_data, 32'h2008_0005);
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("ready_at_first_xfer", req_ready, 0);
        step();
        chk("ready_after_first_xfer", req_ready, 1);
        drain();

        load_en = 1'b1; load_addr = 8'd2; load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h8;
        step(); load_data = 32'h1234_5678; req_valid = 1'b0;
        step(); load_en = 1'b0;
        @(negedge clk);
        chk("wfirst_valid", rsp_valid, 1);
        chk("wfirst_data", rsp_data, 32'hDEAD_BEEF);
        drain();
        req_valid = 1'b1; req_addr = 32'h8;
        step(); req_valid = 1'b0;
        drain();

        base = n_xfer;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        step();
        chk("tput_mid", 32'(n_xfer - base), 5);
        step();
        chk("tput_all", 32'(n_xfer - base), 6);
        drain();

        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", rsp_data, 0);
        step(); step();
        rst_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_ready_pre_edge", req_ready, 0);
        step();
        chk("midrst_ready_post_edge", req_ready, 1);
        chk("midrst_no_rsp", rsp_valid, 0);
        for (int i = 0; i < 4; i++) step();
        chk("midrst_no_xfer", rsp_valid, 0);
        req_valid = 1'b1; req_addr = 32'h0;
        step(); req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("post_reset_valid", rsp_valid, 1);
        chk("post_reset_data", rsp_data, 32'h2008_0005);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
